// File: rtl/mul_bypass_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mul_bypass_unit_pkg                                        |
// | Description : Shared widths, tracker/history entry types and the operand |
// |               source encoding for the multiply bypass/interlock unit.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mul_bypass_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_t;

  // One in-flight multiply slot.
  typedef struct packed {
    logic v;
    reg_t rd;
  } trk_entry_t;

  // One remembered writeback.
  typedef struct packed {
    logic  v;
    reg_t  rd;
    data_t data;
  } hist_entry_t;

  // Where an operand is taken from, youngest producer first.
  typedef enum logic [2:0] {
    SRC_ZERO = 3'd0,
    SRC_ALU  = 3'd1,
    SRC_MUL  = 3'd2,
    SRC_HIST = 3'd3,
    SRC_RF   = 3'd4
  } op_src_e;

  // Valid entry naming a non-zero register equal to src; x0 never matches.
  function automatic logic reg_hit(input logic v, input reg_t entry_rd, input reg_t src);
    return v && (entry_rd == src) && (src != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_bypass_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mul_bypass_unit_if                                         |
// | Description : ID-stage, writeback and EX-side signals of the multiply    |
// |               bypass unit. master = pipeline side, slave = bypass unit.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface mul_bypass_unit_if;
  import mul_bypass_unit_pkg::*;

  logic  flush;
  logic  id_valid;
  reg_t  id_rs1;
  reg_t  id_rs2;
  logic  id_use1;
  logic  id_use2;
  reg_t  id_rd;
  logic  id_wen;
  logic  id_is_mul;
  data_t rf_rdata1;
  data_t rf_rdata2;
  logic  alu_valid;
  reg_t  alu_rd;
  data_t alu_data;
  logic  mul_valid;
  reg_t  mul_rd;
  data_t mul_data;
  logic  stall;
  logic  ex_valid;
  data_t ex_op1;
  data_t ex_op2;
  reg_t  ex_rd;
  logic  ex_is_mul;
  logic  err;

  modport master (
    output flush, id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wen, id_is_mul,
    output rf_rdata1, rf_rdata2, alu_valid, alu_rd, alu_data, mul_valid, mul_rd, mul_data,
    input  stall, ex_valid, ex_op1, ex_op2, ex_rd, ex_is_mul, err
  );

  modport slave (
    input  flush, id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wen, id_is_mul,
    input  rf_rdata1, rf_rdata2, alu_valid, alu_rd, alu_data, mul_valid, mul_rd, mul_data,
    output stall, ex_valid, ex_op1, ex_op2, ex_rd, ex_is_mul, err
  );

endinterface
`default_nettype wire

// File: rtl/mul_bypass_unit_bypass_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bypass_select                                              |
// | Description : Combinational operand selector for one source register:   |
// |               x0 -> ALU writeback -> MUL writeback -> history -> RF.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bypass_select
  import mul_bypass_unit_pkg::*;
#(
  parameter int HIST_DEPTH = 4
) (
  input  reg_t        rs_i,
  input  logic        alu_valid_i,
  input  reg_t        alu_rd_i,
  input  data_t       alu_data_i,
  input  logic        mul_valid_i,
  input  reg_t        mul_rd_i,
  input  data_t       mul_data_i,
  input  hist_entry_t hist_i [HIST_DEPTH],
  input  data_t       rf_rdata_i,
  output data_t       op_o
);

  logic    hist_hit;
  data_t   hist_data;
  op_src_e src_sel;

  // Scan oldest to newest so the youngest matching history entry wins.
  always_comb begin
    hist_hit  = 1'b0;
    hist_data = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (reg_hit(hist_i[i].v, hist_i[i].rd, rs_i)) begin
        hist_hit  = 1'b1;
        hist_data = hist_i[i].data;
      end
    end
  end

  // Priority chain; ALU beats MUL so a same-cycle double write resolves to the ALU value.
  always_comb begin
    src_sel = SRC_RF;
    if (rs_i == '0) begin
      src_sel = SRC_ZERO;
    end else if (alu_valid_i && (alu_rd_i == rs_i)) begin
      src_sel = SRC_ALU;
    end else if (mul_valid_i && (mul_rd_i == rs_i)) begin
      src_sel = SRC_MUL;
    end else if (hist_hit) begin
      src_sel = SRC_HIST;
    end
  end

  // Operand mux driven by the selected source.
  always_comb begin
    op_o = rf_rdata_i;
    case (src_sel)
      SRC_ZERO: op_o = '0;
      SRC_ALU:  op_o = alu_data_i;
      SRC_MUL:  op_o = mul_data_i;
      SRC_HIST: op_o = hist_data;
      default:  op_o = rf_rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mul_bypass_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mul_bypass_unit                                            |
// | Description : ID->EX operand bypass and multiply interlock. Tracks       |
// |               in-flight multiplies, stalls on RAW/WAW against them,      |
// |               keeps a short writeback history and registers operands.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mul_bypass_unit
  import mul_bypass_unit_pkg::*;
#(
  parameter int MUL_LAT    = 3,
  parameter int HIST_DEPTH = 4
) (
  input  logic               clk,
  input  logic               arst_n,
  mul_bypass_unit_if.slave   bus
);

  logic        stall_raw1;
  logic        stall_raw2;
  logic        stall_waw;
  logic        stall;
  logic        issue;

  trk_entry_t  trk_q [MUL_LAT];
  trk_entry_t  trk_d [MUL_LAT];
  trk_entry_t  tail;

  hist_entry_t hist_q [HIST_DEPTH];
  hist_entry_t hist_d [HIST_DEPTH];
  hist_entry_t mul_wb;
  hist_entry_t alu_wb;
  logic        mul_push;
  logic        alu_push;

  logic        err_q;
  logic        err_d;

  logic        ex_valid_q;
  data_t       ex_op1_q;
  data_t       ex_op2_q;
  reg_t        ex_rd_q;
  logic        ex_is_mul_q;

  reg_t        src_rs [2];
  data_t       src_rf [2];
  data_t       src_op [2];

  assign tail = trk_q[MUL_LAT-1];

  // Hazards only against stages whose result is not yet on the multiplier port;
  // a tail match is satisfied by forwarding mul_data instead.
  always_comb begin
    stall_raw1 = 1'b0;
    stall_raw2 = 1'b0;
    stall_waw  = 1'b0;
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      stall_raw1 = stall_raw1 | (bus.id_use1 & reg_hit(trk_q[i].v, trk_q[i].rd, bus.id_rs1));
      stall_raw2 = stall_raw2 | (bus.id_use2 & reg_hit(trk_q[i].v, trk_q[i].rd, bus.id_rs2));
      stall_waw  = stall_waw  | (bus.id_wen  & reg_hit(trk_q[i].v, trk_q[i].rd, bus.id_rd));
    end
    stall = bus.id_valid & (stall_raw1 | stall_raw2 | stall_waw);
  end

  assign issue     = bus.id_valid & ~stall & ~bus.flush;
  assign bus.stall = stall;

  // Tracker next state: shift every cycle, new multiply enters stage 0, flush empties it.
  always_comb begin
    trk_d[0].v  = issue & bus.id_is_mul & bus.id_wen & (bus.id_rd != '0);
    trk_d[0].rd = bus.id_rd;
    for (int i = 1; i < MUL_LAT; i++) begin
      trk_d[i] = trk_q[i-1];
    end
    if (bus.flush) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        trk_d[i] = '0;
      end
    end
  end

  // Tracker state register.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        trk_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MUL_LAT; i++) begin
        trk_q[i] <= trk_d[i];
      end
    end
  end

  // The multiplier must return exactly when and what the tail expects; any slip is sticky.
  always_comb begin
    err_d = err_q
          | (tail.v != bus.mul_valid)
          | (tail.v & bus.mul_valid & (tail.rd != bus.mul_rd));
  end

  // Sticky error flag.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;

  // History push: MUL first, then ALU, so the ALU write ends up youngest (index 0).
  always_comb begin
    mul_push    = bus.mul_valid & (bus.mul_rd != '0);
    alu_push    = bus.alu_valid & (bus.alu_rd != '0);
    mul_wb.v    = 1'b1;
    mul_wb.rd   = bus.mul_rd;
    mul_wb.data = bus.mul_data;
    alu_wb.v    = 1'b1;
    alu_wb.rd   = bus.alu_rd;
    alu_wb.data = bus.alu_data;
    hist_d      = hist_q;
    case ({mul_push, alu_push})
      2'b11: begin
        hist_d[0] = alu_wb;
        hist_d[1] = mul_wb;
        for (int i = 2; i < HIST_DEPTH; i++) begin
          hist_d[i] = hist_q[i-2];
        end
      end
      2'b10: begin
        hist_d[0] = mul_wb;
        for (int i = 1; i < HIST_DEPTH; i++) begin
          hist_d[i] = hist_q[i-1];
        end
      end
      2'b01: begin
        hist_d[0] = alu_wb;
        for (int i = 1; i < HIST_DEPTH; i++) begin
          hist_d[i] = hist_q[i-1];
        end
      end
      default: ;
    endcase
  end

  // History register; flush leaves it alone since those writes really happened.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign src_rs[0] = bus.id_rs1;
  assign src_rs[1] = bus.id_rs2;
  assign src_rf[0] = bus.rf_rdata1;
  assign src_rf[1] = bus.rf_rdata2;

  for (genvar s = 0; s < 2; s++) begin : g_src
    bypass_select #(
      .HIST_DEPTH (HIST_DEPTH)
    ) u_sel (
      .rs_i        (src_rs[s]),
      .alu_valid_i (bus.alu_valid),
      .alu_rd_i    (bus.alu_rd),
      .alu_data_i  (bus.alu_data),
      .mul_valid_i (bus.mul_valid),
      .mul_rd_i    (bus.mul_rd),
      .mul_data_i  (bus.mul_data),
      .hist_i      (hist_q),
      .rf_rdata_i  (src_rf[s]),
      .op_o        (src_op[s])
    );
  end

  // EX register: load on issue, otherwise drop valid and hold the payload.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ex_valid_q  <= 1'b0;
      ex_op1_q    <= '0;
      ex_op2_q    <= '0;
      ex_rd_q     <= '0;
      ex_is_mul_q <= 1'b0;
    end else if (issue) begin
      ex_valid_q  <= 1'b1;
      ex_op1_q    <= src_op[0];
      ex_op2_q    <= src_op[1];
      ex_rd_q     <= bus.id_rd;
      ex_is_mul_q <= bus.id_is_mul;
    end else begin
      ex_valid_q  <= 1'b0;
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_op1    = ex_op1_q;
  assign bus.ex_op2    = ex_op2_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.ex_is_mul = ex_is_mul_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_bypass_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mul_bypass_unit                                         |
// | Description : Self-checking bench for mul_bypass_unit. The bench acts as |
// |               the multiplier and keeps a queue-based reference model.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mul_bypass_unit;

  localparam int MUL_LAT    = 3;
  localparam int HIST_DEPTH = 4;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  mul_bypass_unit_if bus ();

  mul_bypass_unit #(
    .MUL_LAT    (MUL_LAT),
    .HIST_DEPTH (HIST_DEPTH)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: in-flight multiplies as (rd, cycle their result appears),
  // writeback history as a newest-first queue.
  int           cyc = 0;
  int           f_due [$];
  logic [4:0]   f_rd  [$];
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t          hq [$];

  logic         exp_stall, act_stall;
  logic         exp_ex_valid, exp_ex_is_mul, exp_err;
  logic [31:0]  exp_op1, exp_op2;
  logic [4:0]   exp_rd;
  logic [31:0]  mul_result;
  bit           mul_override;

  task automatic set_idle();
    bus.flush = 0; bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_use1 = 0; bus.id_use2 = 0; bus.id_rd = 0; bus.id_wen = 0; bus.id_is_mul = 0;
    bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] rd, input logic wen, input logic is_mul);
    bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_use1 = u1; bus.id_rs2 = rs2; bus.id_use2 = u2;
    bus.id_rd = rd; bus.id_wen = wen; bus.id_is_mul = is_mul;
    bus.rf_rdata1 = $urandom; bus.rf_rdata2 = $urandom;
  endtask

  function automatic logic pending(input logic [4:0] r);
    if (r == 0) return 1'b0;
    foreach (f_due[i]) if (f_due[i] > cyc && f_rd[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_op(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'h0;
    if (bus.alu_valid && bus.alu_rd == rs) return bus.alu_data;
    if (bus.mul_valid && bus.mul_rd == rs) return bus.mul_data;
    foreach (hq[i]) if (hq[i].rd == rs) return hq[i].data;
    return rf;
  endfunction

  // One clock: act as the multiplier, predict stall and next EX/err, advance the model.
  task automatic step();
    int          tail_idx;
    logic        tail_v, iss, n_err;
    logic [4:0]  tail_rd;
    logic [31:0] n_op1, n_op2;
    wb_t         e;
    @(negedge clk);
    tail_idx = -1;
    foreach (f_due[i]) if (f_due[i] == cyc) tail_idx = i;
    tail_v  = (tail_idx >= 0);
    tail_rd = tail_v ? f_rd[tail_idx] : 5'd0;
    if (!mul_override) begin
      bus.mul_valid = tail_v;
      bus.mul_rd    = tail_rd;
      bus.mul_data  = mul_result;
    end
    #1;
    act_stall = bus.stall;
    exp_stall = bus.id_valid && ((bus.id_use1 && pending(bus.id_rs1)) ||
                                 (bus.id_use2 && pending(bus.id_rs2)) ||
                                 (bus.id_wen  && pending(bus.id_rd)));
    iss   = bus.id_valid && !exp_stall && !bus.flush;
    n_op1 = ref_op(bus.id_rs1, bus.rf_rdata1);
    n_op2 = ref_op(bus.id_rs2, bus.rf_rdata2);
    n_err = exp_err || (tail_v != bus.mul_valid) || (tail_v && bus.mul_valid && tail_rd != bus.mul_rd);
    @(posedge clk);
    #1;
    if (!arst_n) begin
      f_due.delete(); f_rd.delete(); hq.delete();
      exp_ex_valid = 0; exp_op1 = 0; exp_op2 = 0; exp_rd = 0; exp_ex_is_mul = 0; exp_err = 0;
    end else begin
      exp_err      = n_err;
      exp_ex_valid = iss;
      if (iss) begin
        exp_op1 = n_op1; exp_op2 = n_op2; exp_rd = bus.id_rd; exp_ex_is_mul = bus.id_is_mul;
      end
      if (bus.flush) begin
        f_due.delete(); f_rd.delete();
      end
      for (int i = f_due.size() - 1; i >= 0; i--) begin
        if (f_due[i] <= cyc) begin
          f_due.delete(i); f_rd.delete(i);
        end
      end
      if (iss && bus.id_is_mul && bus.id_wen && bus.id_rd != 0) begin
        f_due.push_back(cyc + MUL_LAT); f_rd.push_back(bus.id_rd);
      end
      if (bus.mul_valid && bus.mul_rd != 0) begin
        e.rd = bus.mul_rd; e.data = bus.mul_data; hq.push_front(e);
      end
      if (bus.alu_valid && bus.alu_rd != 0) begin
        e.rd = bus.alu_rd; e.data = bus.alu_data; hq.push_front(e);
      end
      while (hq.size() > HIST_DEPTH) void'(hq.pop_back());
    end
    cyc++;
  endtask

  task automatic test_reset();
    arst_n = 0; set_idle(); step(); step(); arst_n = 1;
    n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_op1 !== 32'h0 || bus.err !== 1'b0) begin
      n_bad++; $display("FAIL reset_init: valid=%b op1=%h err=%b required 0/0/0", bus.ex_valid, bus.ex_op1, bus.err);
    end
    set_instr(5'd1, 1, 5'd2, 1, 5'd5, 1, 1); step();
    n_cmp++; if (bus.ex_valid !== 1'b1) begin
      n_bad++; $display("FAIL reset_pre_issue: ex_valid=%b required 1", bus.ex_valid);
    end
    arst_n = 0; set_idle(); step(); step(); arst_n = 1;
    n_cmp++; if ({bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.ex_rd, bus.ex_is_mul, bus.err} !== '0) begin
      n_bad++; $display("FAIL reset_mid: valid=%b op1=%h op2=%h rd=%0d mul=%b err=%b required all 0",
                        bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.ex_rd, bus.ex_is_mul, bus.err);
    end
    set_instr(5'd5, 1, 5'd0, 0, 5'd6, 1, 0); step();
    n_cmp++; if (act_stall !== 1'b0 || act_stall !== exp_stall) begin
      n_bad++; $display("FAIL reset_tracker: stall=%b required 0", act_stall);
    end
  endtask

  task automatic test_mul_raw();
    mul_result = 32'h1234;
    set_idle(); set_instr(5'd1, 1, 5'd2, 1, 5'd5, 1, 1); step();
    n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_is_mul !== 1'b1 || bus.ex_rd !== 5'd5) begin
      n_bad++; $display("FAIL raw_mul_issue: valid=%b mul=%b rd=%0d required 1/1/5", bus.ex_valid, bus.ex_is_mul, bus.ex_rd);
    end
    set_instr(5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      step();
      n_cmp++; if (act_stall !== 1'b1 || exp_stall !== 1'b1 || bus.ex_valid !== 1'b0) begin
        n_bad++; $display("FAIL raw_stall[%0d]: stall=%b ex_valid=%b required 1/0", k, act_stall, bus.ex_valid);
      end
    end
    step();
    n_cmp++; if (act_stall !== 1'b0 || bus.ex_valid !== 1'b1 || bus.ex_op1 !== 32'h1234) begin
      n_bad++; $display("FAIL raw_forward: stall=%b valid=%b op1=%h required 0/1/00001234", act_stall, bus.ex_valid, bus.ex_op1);
    end
  endtask

  task automatic test_alu_mul_collision();
    mul_result = 32'hBB;
    set_idle(); set_instr(5'd0, 0, 5'd0, 0, 5'd7, 1, 1); step();
    set_idle(); step(); step();
    set_instr(5'd0, 0, 5'd7, 1, 5'd8, 1, 0);
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'hAA;
    step();
    n_cmp++; if (bus.ex_op2 !== 32'hAA || bus.ex_op2 !== exp_op2) begin
      n_bad++; $display("FAIL collide_fwd: op2=%h required 000000aa", bus.ex_op2);
    end
    set_idle(); set_instr(5'd7, 1, 5'd7, 1, 5'd9, 1, 0); step();
    n_cmp++; if (bus.ex_op1 !== 32'hAA || bus.ex_op2 !== 32'hAA) begin
      n_bad++; $display("FAIL collide_hist: op1=%h op2=%h required 000000aa", bus.ex_op1, bus.ex_op2);
    end
  endtask

  task automatic test_history_age();
    set_idle();
    for (int k = 1; k <= 5; k++) begin
      bus.alu_valid = 1; bus.alu_rd = k[4:0]; bus.alu_data = 32'h100 + k; step();
    end
    set_idle(); set_instr(5'd1, 1, 5'd0, 0, 5'd9, 1, 0); bus.rf_rdata1 = 32'h55; step();
    n_cmp++; if (bus.ex_op1 !== 32'h55 || bus.ex_op1 !== exp_op1) begin
      n_bad++; $display("FAIL hist_aged: op1=%h required 00000055", bus.ex_op1);
    end
    set_instr(5'd2, 1, 5'd0, 0, 5'd9, 1, 0); bus.rf_rdata1 = 32'h55; step();
    n_cmp++; if (bus.ex_op1 !== 32'h102) begin
      n_bad++; $display("FAIL hist_hit: op1=%h required 00000102", bus.ex_op1);
    end
  endtask

  task automatic test_waw_flush();
    set_idle(); set_instr(5'd0, 0, 5'd0, 0, 5'd3, 1, 1); step();
    set_instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      step();
      n_cmp++; if (act_stall !== 1'b1) begin
        n_bad++; $display("FAIL waw_stall[%0d]: stall=%b required 1", k, act_stall);
      end
    end
    step();
    n_cmp++; if (act_stall !== 1'b0 || bus.ex_valid !== 1'b1) begin
      n_bad++; $display("FAIL waw_release: stall=%b valid=%b required 0/1", act_stall, bus.ex_valid);
    end
    set_instr(5'd0, 0, 5'd0, 0, 5'd3, 1, 1); step();
    set_instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0); bus.flush = 1; step();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_kill: ex_valid=%b required 0", bus.ex_valid);
    end
    bus.flush = 0; step();
    n_cmp++; if (act_stall !== 1'b0 || bus.ex_valid !== 1'b1) begin
      n_bad++; $display("FAIL flush_clear: stall=%b valid=%b required 0/1", act_stall, bus.ex_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic hold;
    hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        set_idle();
        if ($urandom_range(0, 9) < 8)
          set_instr(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                    5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));
      end
      bus.flush     = ($urandom_range(0, 24) == 0);
      bus.alu_valid = 1'($urandom);
      bus.alu_rd    = 5'($urandom_range(0, 7));
      bus.alu_data  = $urandom;
      bus.rf_rdata1 = $urandom;
      bus.rf_rdata2 = $urandom;
      mul_result    = $urandom;
      step();
      n_cmp++; if (act_stall !== exp_stall) begin
        n_bad++; $display("FAIL rnd_stall @%0d: got %b required %b", n, act_stall, exp_stall);
      end
      n_cmp++; if (bus.ex_valid !== exp_ex_valid || bus.ex_op1 !== exp_op1 || bus.ex_op2 !== exp_op2 ||
                   bus.ex_rd !== exp_rd || bus.ex_is_mul !== exp_ex_is_mul || bus.err !== exp_err) begin
        n_bad++; $display("FAIL rnd_ex @%0d: got v=%b %h %h rd=%0d m=%b e=%b required v=%b %h %h rd=%0d m=%b e=%b",
                          n, bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.ex_rd, bus.ex_is_mul, bus.err,
                          exp_ex_valid, exp_op1, exp_op2, exp_rd, exp_ex_is_mul, exp_err);
      end
      hold = exp_stall && !bus.flush;
    end
  endtask

  task automatic test_err_x0();
    set_idle(); bus.flush = 1; step();
    set_idle(); set_instr(5'd0, 1, 5'd0, 1, 5'd1, 1, 0);
    bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFF;
    step();
    n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_op1 !== 32'h0 || bus.ex_op2 !== 32'h0) begin
      n_bad++; $display("FAIL x0_read: valid=%b op1=%h op2=%h required 1/0/0", bus.ex_valid, bus.ex_op1, bus.ex_op2);
    end
    n_cmp++; if (bus.err !== 1'b0) begin
      n_bad++; $display("FAIL err_clean: err=%b required 0", bus.err);
    end
    set_idle(); mul_override = 1;
    bus.mul_valid = 1; bus.mul_rd = 5'd9; bus.mul_data = 32'h0;
    step();
    mul_override = 0;
    n_cmp++; if (bus.err !== 1'b1 || exp_err !== 1'b1) begin
      n_bad++; $display("FAIL err_set: err=%b required 1", bus.err);
    end
    step(); step();
    n_cmp++; if (bus.err !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky: err=%b required 1", bus.err);
    end
  endtask

  initial begin
    arst_n = 0; mul_override = 0; mul_result = 0;
    exp_stall = 0; act_stall = 0; exp_ex_valid = 0; exp_ex_is_mul = 0; exp_err = 0;
    exp_op1 = 0; exp_op2 = 0; exp_rd = 0;
    bus.mul_valid = 0; bus.mul_rd = 0; bus.mul_data = 0;
    set_idle();
    test_reset();
    test_mul_raw();
    test_alu_mul_collision();
    test_history_age();
    test_waw_flush();
    test_back_to_back();
    test_err_x0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
